// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed Booth multiplier with a start/done handshake.
// Radix-2 by default; defining BOOTH_RADIX4_EN selects radix-4 recoding (half the RUN cycles).
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
`ifdef BOOTH_RADIX4_EN
    localparam int SH = 2;
`else
    localparam int SH = 1;
`endif
    localparam int N  = WIDTH / SH;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        m_q, m_d, a_q, a_d, addend, sum;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [AW+WIDTH:0]    shifted;
    logic [AW-1:0]        m2;
`ifdef BOOTH_RADIX4_EN
    logic [2:0]           r;
`else
    logic [1:0]           r;
`endif

    always_comb begin
        m2 = {m_q[AW-2:0], 1'b0};
`ifdef BOOTH_RADIX4_EN
        r = {q_q[1:0], q1_q};
        addend = (r == 3'b001 || r == 3'b010) ? m_q :
                 (r == 3'b011)                 ? m2 :
                 (r == 3'b100)                 ? -m2 :
                 (r == 3'b101 || r == 3'b110) ? -m_q : '0;
`else
        r = {q_q[0], q1_q};
        addend = (r == 2'b01) ? m_q : (r == 2'b10) ? -m_q : '0;
`endif
        sum = a_q + addend;
        // Shift the whole {A,Q,Q_1} chain so A's sign fills from the top.
        shifted = $signed({sum, q_q, q1_q}) >>> SH;
        state_d = state_q;
        m_d = m_q;
        a_d = a_q;
        q_d = q_q;
        q1_d = q1_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        product_d = product_q;
        if (state_q == RUN) begin
            if (cnt_q == CW'(N)) begin
                state_d = FIN;
                busy_d = 1'b0;
                done_d = 1'b1;
                product_d = {a_q[WIDTH-1:0], q_q};
            end else begin
                {a_d, q_d, q1_d} = shifted;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (start) begin
            state_d = RUN;
            busy_d = 1'b1;
            m_d = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            a_d = '0;
            q_d = multiplier;
            q1_d = 1'b0;
            cnt_d = '0;
        end else begin
            state_d = IDLE;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q <= '0;
            a_q <= '0;
            q_q <= '0;
            q1_q <= 1'b0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            m_q <= m_d;
            a_q <= a_d;
            q_q <= q_d;
            q1_q <= q1_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            product_q <= product_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and back-to-back random checks of booth_mul_seq (WIDTH=8).
module tb_booth_mul_seq;
    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int N = W / 2;
`else
    localparam int N = W;
`endif
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   mc = '0;
    logic [W-1:0]   mp = '0;
    logic           busy, done;
    logic [2*W-1:0] product;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .multiplicand(mc), .multiplier(mp),
        .busy(busy), .done(done), .product(product)
    );

    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, output int lat,
                         output logic [2*W-1:0] p, output logic busy_ok);
        lat = -1;
        p = 'x;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mc = m;
        mp = q;
        @(posedge clk);
        #1 start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= N + 8; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                p = product;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (product !== 16'h0000) $display("FAIL reset_product got %h want 0000", product); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        logic [2*W-1:0] p;
        logic bok;
        do_op(8'd3, 8'd5, lat, p, bok);
        checks++; if (lat !== N + 1) $display("FAIL basic_latency got %0d want %0d", lat, N + 1); else passed++;
        checks++; if (p !== 16'h000F) $display("FAIL basic_product got %h want 000f", p); else passed++;
        checks++; if (bok !== 1'b1) $display("FAIL basic_busy got %b want 1", bok); else passed++;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
        checks++; if (product !== 16'h000F) $display("FAIL basic_hold got %h want 000f", product); else passed++;
    endtask

    task automatic test_mixed_sign;
        int lat;
        logic [2*W-1:0] p;
        logic bok;
        do_op(8'hF9, 8'd6, lat, p, bok);
        checks++; if (p !== 16'hFFD6) $display("FAIL mixed_product got %h want ffd6", p); else passed++;
        do_op(8'd6, 8'hF9, lat, p, bok);
        checks++; if (p !== 16'hFFD6) $display("FAIL mixed_swap_product got %h want ffd6", p); else passed++;
        checks++; if (lat !== N + 1) $display("FAIL mixed_latency got %0d want %0d", lat, N + 1); else passed++;
    endtask

    task automatic test_extremes;
        int lat;
        logic [2*W-1:0] p;
        logic bok;
        do_op(8'h80, 8'h80, lat, p, bok);
        checks++; if (p !== 16'h4000) $display("FAIL ext_min_min got %h want 4000", p); else passed++;
        do_op(8'h80, 8'h7F, lat, p, bok);
        checks++; if (p !== 16'hC080) $display("FAIL ext_min_max got %h want c080", p); else passed++;
        do_op(8'h7F, 8'h7F, lat, p, bok);
        checks++; if (p !== 16'h3F01) $display("FAIL ext_max_max got %h want 3f01", p); else passed++;
    endtask

    task automatic test_busy_protection;
        int dones = 0;
        logic bok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mc = 8'd2;
        mp = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 2 * N + 6; k++) begin
            @(posedge clk);
            #1;
            if (k <= N && busy !== 1'b1) bok = 1'b0;
            if (done === 1'b1) dones++;
            if (k == 2) begin
                start = 1'b1;
                mc = 8'd9;
                mp = 8'd9;
            end
            if (k == 3) start = 1'b0;
        end
        checks++; if (dones !== 1) $display("FAIL busy_done_count got %0d want 1", dones); else passed++;
        checks++; if (product !== 16'h0006) $display("FAIL busy_product got %h want 0006", product); else passed++;
        checks++; if (bok !== 1'b1) $display("FAIL busy_high_in_run got %b want 1", bok); else passed++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int lat;
        logic [2*W-1:0] p;
        logic bok;
        @(negedge clk);
        start = 1'b1;
        mc = 8'd5;
        mp = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
        checks++; if (product !== 16'h0000) $display("FAIL rstmid_product got %h want 0000", product); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2 * N + 4; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL rstmid_no_done got %0d want 0", dones); else passed++;
        do_op(8'hFF, 8'hFF, lat, p, bok);
        checks++; if (p !== 16'h0001) $display("FAIL rstmid_neg1_product got %h want 0001", p); else passed++;
        checks++; if (lat !== N + 1) $display("FAIL rstmid_latency got %0d want %0d", lat, N + 1); else passed++;
    endtask

    task automatic test_back_to_back;
        logic signed [W-1:0] cm, cq;
        logic [2*W-1:0] exp_p;
        logic exp_done;
        int expv = 0;
        int dones = 0;
        int bad = 0;
        @(negedge clk);
        cm = W'($urandom);
        cq = W'($urandom);
        mc = cm;
        mp = cq;
        start = 1'b1;
        for (int e = 0; e < 1000 * (N + 2); e++) begin
            @(posedge clk);
            if (e % (N + 2) == 0) expv = int'(cm) * int'(cq);
            #1;
            exp_done = (e % (N + 2) == N + 1);
            if (done === 1'b1) dones++;
            checks++;
            if (done !== exp_done) begin
                bad++;
                if (bad < 10) $display("FAIL b2b_done edge %0d got %b want %b", e, done, exp_done);
            end else passed++;
            if (exp_done) begin
                exp_p = expv[2*W-1:0];
                checks++;
                if (product !== exp_p) begin
                    bad++;
                    if (bad < 10) $display("FAIL b2b_product edge %0d got %h want %h", e, product, exp_p);
                end else passed++;
            end
            cm = W'($urandom);
            cq = W'($urandom);
            mc = cm;
            mp = cq;
        end
        start = 1'b0;
        checks++; if (dones !== 1000) $display("FAIL b2b_done_count got %0d want 1000", dones); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mixed_sign;
        test_extremes;
        test_busy_protection;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
